// File: rtl/regfile_dump_pkg.sv
// Shared constants and FSM state type for the register-file dump sweeper.
package regfile_dump_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREGS  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StSend
  } state_e;

endpackage

// File: rtl/regfile_dump.sv
// Walks a wrapping range of register indices through a spare regfile read port and
// streams each byte out over valid/ready, pulsing done after the final handshake.
module regfile_dump
  import regfile_dump_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_idx,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  state_e            state;
  logic [ADDR_W-1:0] cur_idx;
  logic [ADDR_W-1:0] end_idx;
  logic [ADDR_W-1:0] cur_next;

  // Index arithmetic wraps at NREGS, so a range with first > last crosses the top.
  assign cur_next = (cur_idx == ADDR_W'(NREGS - 1)) ? '0 : cur_idx + 1'b1;

  assign rd_idx = cur_idx;
  assign busy   = (state != StIdle);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= StIdle;
      cur_idx <= '0;
      end_idx <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_idx   <= '0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            cur_idx <= first_idx;
            end_idx <= last_idx;
            state   <= StFetch;
          end
        end
        StFetch: begin
          m_data  <= rd_data;
          m_idx   <= cur_idx;
          m_last  <= (cur_idx == end_idx);
          m_valid <= 1'b1;
          state   <= StSend;
        end
        StSend: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            if (cur_idx == end_idx) begin
              done  <= 1'b1;
              state <= StIdle;
            end else begin
              cur_idx <= cur_next;
              state   <= StFetch;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
